// File: rtl/fir_chan_sched.sv
// Four-channel sample scheduler in front of a single shared FIR pipeline.
// Holds one sample per channel, issues them round-robin, and changes the pass/FIR select only once the pipeline is empty.
module fir_chan_sched #(
    parameter int INBITWIDTH = 18,
    parameter int FIR_LAT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            ch_flag,
    input  logic [INBITWIDTH-1:0] ch_data0,
    input  logic [INBITWIDTH-1:0] ch_data1,
    input  logic [INBITWIDTH-1:0] ch_data2,
    input  logic [INBITWIDTH-1:0] ch_data3,
    input  logic                  fir_ready,
    input  logic                  pass_req,
    input  logic                  ovf_clr,
    output logic                  fir_in_flag,
    output logic [INBITWIDTH-1:0] fir_in_data,
    output logic [1:0]            fir_in_ch,
    output logic                  fir_pass_flag,
    output logic [3:0]            pend,
    output logic [3:0]            overflow,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_pass;
    logic [3:0]            r_pend;
    logic [3:0]            r_ovf;
    logic [INBITWIDTH-1:0] r_hold [4];
    logic [1:0]            r_last;
    logic [7:0]            r_flush;
    logic                  r_out_flag;
    logic [INBITWIDTH-1:0] r_out_data;
    logic [1:0]            r_out_ch;

    logic [INBITWIDTH-1:0] w_ch_data [4];
    logic                  w_grant;
    logic [1:0]            w_grant_ch;
    logic [1:0]            w_idx;
    logic [3:0]            w_grant_vec;
    logic [3:0]            w_ovf_set;

    assign w_ch_data[0] = ch_data0;
    assign w_ch_data[1] = ch_data1;
    assign w_ch_data[2] = ch_data2;
    assign w_ch_data[3] = ch_data3;

    // Round-robin: search starts just after the last granted channel and wraps.
    always_comb begin
        w_grant    = 1'b0;
        w_grant_ch = 2'd0;
        w_idx      = 2'd0;
        if (fir_ready && (r_state != ST_SWITCH) && (|r_pend)) begin
            for (int k = 1; k <= 4; k++) begin
                w_idx = r_last + 2'(k);
                if (!w_grant && r_pend[w_idx]) begin
                    w_grant    = 1'b1;
                    w_grant_ch = w_idx;
                end
            end
        end
    end

    always_comb begin
        w_grant_vec = 4'd0;
        w_ovf_set   = 4'd0;
        for (int i = 0; i < 4; i++) begin
            w_grant_vec[i] = w_grant && (w_grant_ch == 2'(i));
            w_ovf_set[i]   = ch_flag[i] && r_pend[i] && !w_grant_vec[i];
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (pass_req != r_pass) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pass_req == r_pass)
                    w_state_next = ST_RUN;
                else if ((r_pend == 4'd0) && (r_flush == 8'd0) && !w_grant)
                    w_state_next = ST_SWITCH;
            end
            ST_SWITCH: w_state_next = ST_RUN;
            default:   w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pass     <= 1'b0;
            r_pend     <= 4'd0;
            r_ovf      <= 4'd0;
            r_last     <= 2'd3;
            r_flush    <= 8'd0;
            r_out_flag <= 1'b0;
            r_out_data <= '0;
            r_out_ch   <= 2'd0;
            for (int i = 0; i < 4; i++) r_hold[i] <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_SWITCH) r_pass <= ~r_pass;

            r_out_flag <= w_grant;
            if (w_grant) begin
                r_out_data <= r_hold[w_grant_ch];
                r_out_ch   <= w_grant_ch;
                r_last     <= w_grant_ch;
                r_flush    <= 8'(FIR_LAT);
            end else if (r_flush != 8'd0) begin
                r_flush <= r_flush - 8'd1;
            end

            // A strobe on the channel being granted refills the slot it just vacated.
            for (int i = 0; i < 4; i++) begin
                if (ch_flag[i] && (!r_pend[i] || w_grant_vec[i])) begin
                    r_hold[i] <= w_ch_data[i];
                    r_pend[i] <= 1'b1;
                end else if (w_grant_vec[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end

            r_ovf <= ovf_clr ? 4'd0 : (r_ovf | w_ovf_set);
        end
    end

    assign fir_in_flag   = r_out_flag;
    assign fir_in_data   = r_out_data;
    assign fir_in_ch     = r_out_ch;
    assign fir_pass_flag = r_pass;
    assign pend          = r_pend;
    assign overflow      = r_ovf;
    assign busy          = (r_state != ST_RUN);

endmodule

// File: tb/tb_fir_chan_sched.sv
// Directed bench for fir_chan_sched: round-robin issue, overflow, in-grant refill, mode switch, abort and reset.
module tb_fir_chan_sched;

    localparam int W = 18;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   ch_flag;
    logic [W-1:0] ch_data0, ch_data1, ch_data2, ch_data3;
    logic         fir_ready, pass_req, ovf_clr;
    logic         fir_in_flag;
    logic [W-1:0] fir_in_data;
    logic [1:0]   fir_in_ch;
    logic         fir_pass_flag;
    logic [3:0]   pend, overflow;
    logic         busy;

    int total = 0;
    int bad   = 0;

    fir_chan_sched #(.INBITWIDTH(W), .FIR_LAT(8)) dut (
        .clk(clk), .rst(rst), .ch_flag(ch_flag),
        .ch_data0(ch_data0), .ch_data1(ch_data1), .ch_data2(ch_data2), .ch_data3(ch_data3),
        .fir_ready(fir_ready), .pass_req(pass_req), .ovf_clr(ovf_clr),
        .fir_in_flag(fir_in_flag), .fir_in_data(fir_in_data), .fir_in_ch(fir_in_ch),
        .fir_pass_flag(fir_pass_flag), .pend(pend), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit later, inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_chk(input string tag, input logic [1:0] ch, input logic [W-1:0] data);
        check({tag, "_flag"}, 32'(fir_in_flag), 32'd1);
        check({tag, "_ch"},   32'(fir_in_ch),   32'(ch));
        check({tag, "_data"}, 32'(fir_in_data), 32'(data));
    endtask

    initial begin
        rst = 1'b1; ch_flag = 4'd0; fir_ready = 1'b0; pass_req = 1'b0; ovf_clr = 1'b0;
        ch_data0 = '0; ch_data1 = '0; ch_data2 = '0; ch_data3 = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_pend", 32'(pend), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_flag", 32'(fir_in_flag), 32'h0);
        check("rst_data", 32'(fir_in_data), 32'h0);
        check("rst_ch", 32'(fir_in_ch), 32'h0);
        check("rst_pass", 32'(fir_pass_flag), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Round-robin from reset priority: ch0..ch3 on consecutive cycles.
        fir_ready = 1'b1; ch_flag = 4'b1111;
        ch_data0 = 18'h00011; ch_data1 = 18'h00022; ch_data2 = 18'h00033; ch_data3 = 18'h00044;
        tick();
        ch_flag = 4'd0;
        check("rr_pend", 32'(pend), 32'hF);
        check("rr_noflag_t1", 32'(fir_in_flag), 32'h0);
        tick(); issue_chk("rr0", 2'd0, 18'h00011);
        tick(); issue_chk("rr1", 2'd1, 18'h00022);
        tick(); issue_chk("rr2", 2'd2, 18'h00033);
        tick(); issue_chk("rr3", 2'd3, 18'h00044);
        tick();
        check("rr_idle_flag", 32'(fir_in_flag), 32'h0);
        check("rr_idle_data_hold", 32'(fir_in_data), 32'h00044);
        check("rr_idle_pend", 32'(pend), 32'h0);

        // Overflow on ch1, then clear having priority over a simultaneous set.
        fir_ready = 1'b0; ch_flag = 4'b0010; ch_data1 = 18'h00AAA;
        tick();
        ch_data1 = 18'h00BBB;
        tick();
        check("ovf_pend", 32'(pend), 32'h2);
        check("ovf_set", 32'(overflow), 32'h2);
        ch_data1 = 18'h00CCC; ovf_clr = 1'b1;
        tick();
        check("ovf_clr_prio", 32'(overflow), 32'h0);
        ch_flag = 4'd0; ovf_clr = 1'b0; fir_ready = 1'b1;
        tick(); issue_chk("ovf_issue", 2'd1, 18'h00AAA);
        tick();
        check("ovf_pend_clr", 32'(pend), 32'h0);

        // Strobe on ch0 in the cycle ch0 is granted.
        fir_ready = 1'b0; ch_flag = 4'b0001; ch_data0 = 18'h00111;
        tick();
        fir_ready = 1'b1; ch_data0 = 18'h00222;
        tick();
        ch_flag = 4'd0;
        issue_chk("same_old", 2'd0, 18'h00111);
        check("same_pend", 32'(pend), 32'h1);
        check("same_ovf", 32'(overflow), 32'h0);
        tick(); issue_chk("same_new", 2'd0, 18'h00222);

        // Wrap: last grant was ch0, so ch3 beats ch0.
        fir_ready = 1'b0; ch_flag = 4'b1001; ch_data0 = 18'h00005; ch_data3 = 18'h00006;
        tick();
        ch_flag = 4'd0; fir_ready = 1'b1;
        tick(); issue_chk("wrap_ch3", 2'd3, 18'h00006);
        tick(); issue_chk("wrap_ch0", 2'd0, 18'h00005);
        tick();
        check("wrap_idle", 32'(fir_in_flag), 32'h0);

        // Abort: pass_req high for 3 cycles while the flush counter is still large.
        fir_ready = 1'b0; ch_flag = 4'b0010; ch_data1 = 18'h00044;
        tick();
        ch_flag = 4'd0; fir_ready = 1'b1; pass_req = 1'b1;
        tick();
        issue_chk("abort_issue", 2'd1, 18'h00044);
        check("abort_busy0", 32'(busy), 32'h1);
        tick();
        check("abort_busy1", 32'(busy), 32'h1);
        tick();
        check("abort_busy2", 32'(busy), 32'h1);
        pass_req = 1'b0;
        tick();
        check("abort_busy_drop", 32'(busy), 32'h0);
        check("abort_pass", 32'(fir_pass_flag), 32'h0);
        repeat (3) tick();
        check("abort_pass_later", 32'(fir_pass_flag), 32'h0);

        // Mode switch: flag rises 10 edges after the grant edge.
        fir_ready = 1'b0; ch_flag = 4'b0100; ch_data2 = 18'h00333;
        tick();
        ch_flag = 4'd0; fir_ready = 1'b1; pass_req = 1'b1;
        tick();
        issue_chk("sw_issue", 2'd2, 18'h00333);
        check("sw_busy", 32'(busy), 32'h1);
        repeat (9) tick();
        check("sw_pass_e9", 32'(fir_pass_flag), 32'h0);
        check("sw_busy_e9", 32'(busy), 32'h1);
        tick();
        check("sw_pass_e10", 32'(fir_pass_flag), 32'h1);
        check("sw_busy_e10", 32'(busy), 32'h0);

        // Reset in DRAIN with ch0 and ch2 held; strobes during reset are ignored.
        fir_ready = 1'b0; ch_flag = 4'b0101; ch_data0 = 18'h00077; ch_data2 = 18'h00088;
        tick();
        ch_flag = 4'd0; pass_req = 1'b0;
        check("mid_pend", 32'(pend), 32'h5);
        tick();
        check("mid_busy", 32'(busy), 32'h1);
        rst = 1'b1; ch_flag = 4'b1111;
        tick();
        rst = 1'b0; ch_flag = 4'd0;
        check("mid_rst_pend", 32'(pend), 32'h0);
        check("mid_rst_flag", 32'(fir_in_flag), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_pass", 32'(fir_pass_flag), 32'h0);
        check("mid_rst_data", 32'(fir_in_data), 32'h0);
        fir_ready = 1'b1;
        tick(); tick();
        check("mid_rst_noissue", 32'(fir_in_flag), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
